// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types and constants for the bridge target-side logic.
//   - target_cmd_arb_state_e : state encoding of the target command arbiter
//   - TGT_CMD_*              : target command words issued by core requesters
//   - TARGET_CMD_TIMEOUT_DEFAULT : default engine-stall abort threshold (cycles)
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } target_cmd_arb_state_e;

    // Target command words (core -> host)
    localparam logic [15:0] TGT_CMD_DATASLOT_OPEN  = 16'h0180;
    localparam logic [15:0] TGT_CMD_DATASLOT_READ  = 16'h0181;
    localparam logic [15:0] TGT_CMD_DATASLOT_WRITE = 16'h0182;
    localparam logic [15:0] TGT_CMD_SAVESTATE_DONE = 16'h0190;
    localparam logic [15:0] TGT_CMD_RTC_GET        = 16'h01A0;

    localparam int TARGET_CMD_TIMEOUT_DEFAULT = 1048576;

endpackage

// File: rtl/bridge_target_cmd_arb_chk.sv
// bridge_target_cmd_arb_chk: protocol checker for the target command arbiter.
//   Observes grant/response pulses, the issue pulse and the registered
//   command word/param; flags protocol violations.
module bridge_target_cmd_arb_chk
    import bridge_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PARAM_W = 64
) (
    input logic               clk,
    input logic               reset,
    input logic [1:0]         state,
    input logic [NUM_REQ-1:0] req_grant,
    input logic [NUM_REQ-1:0] rsp_valid,
    input logic               tgt_valid,
    input logic [15:0]        tgt_word,
    input logic [PARAM_W-1:0] tgt_param
);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_grant));

    a_rsp_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(rsp_valid));

    // tgt_valid is registered on the ISSUE->WAIT transition
    a_tgt_valid_from_issue: assert property (@(posedge clk) disable iff (reset)
        tgt_valid |-> (state == WAIT) && ($past(state) == ISSUE));

    // word/param are captured on entry to ISSUE and held until back in IDLE
    a_cmd_stable: assert property (@(posedge clk) disable iff (reset)
        (state != IDLE) && ($past(state) != IDLE) |-> $stable(tgt_word) && $stable(tgt_param));

endmodule

// File: rtl/bridge_target_cmd_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   [N]  : request vector
//   ptr   [PW] : index with highest priority; search goes ptr, ptr+1, ... mod N
//   grant [N]  : one-hot grant (all zero when no request)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx_s;
    logic          found_s;

    // first set request at or after ptr, wrapping around
    always_comb begin
        grant   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx_s = PW'((int'(ptr) + i) % N);
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/bridge_target_cmd_arb.sv
// bridge_target_cmd_arb: shares the single target command channel between
// NUM_REQ core requesters with round-robin arbitration, one command in flight.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   enable                : gate for new grants (in-flight command unaffected)
//   req_valid/word/param  : per-requester command request (held until grant)
//   req_grant             : one-hot pulse, request captured
//   rsp_valid/result/timeout : one-hot completion pulse to the owner
//   tgt_valid/word/param  : command issue to the target engine
//   tgt_ready/done/result : engine handshake and result
//   tgt_abort             : pulse on engine stall timeout
//   busy                  : high whenever not IDLE
module bridge_target_cmd_arb
    import bridge_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int PARAM_W        = 64,
    parameter int TIMEOUT_CYCLES = TARGET_CMD_TIMEOUT_DEFAULT,
    parameter int TO_W           = 21
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*16-1:0]      req_word,
    input  logic [NUM_REQ*PARAM_W-1:0] req_param,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [15:0]                rsp_result,
    output logic                       rsp_timeout,
    output logic                       tgt_valid,
    output logic [15:0]                tgt_word,
    output logic [PARAM_W-1:0]         tgt_param,
    input  logic                       tgt_ready,
    input  logic                       tgt_done,
    input  logic [15:0]                tgt_result,
    output logic                       tgt_abort,
    output logic                       busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

    target_cmd_arb_state_e state_r, state_nxt_s;
    logic [IW-1:0]         rr_r, rr_nxt_s;
    logic [IW-1:0]         owner_r, owner_nxt_s;
    logic [TO_W-1:0]       cnt_r, cnt_nxt_s;
    logic [15:0]           word_r, word_nxt_s;
    logic [PARAM_W-1:0]    param_r, param_nxt_s;
    logic [NUM_REQ-1:0]    grant_r, grant_nxt_s;
    logic [NUM_REQ-1:0]    rsp_valid_r, rsp_valid_nxt_s;
    logic [15:0]           rsp_result_r, rsp_result_nxt_s;
    logic                  rsp_timeout_r, rsp_timeout_nxt_s;
    logic                  tgt_valid_r, tgt_valid_nxt_s;
    logic                  tgt_abort_r, tgt_abort_nxt_s;
    logic                  busy_r;
    logic [NUM_REQ-1:0]    arb_grant_s;
    logic [NUM_REQ-1:0]    owner_onehot_s;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (IW)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_r),
        .grant (arb_grant_s)
    );

    assign owner_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;

    // next-state and next-output decode
    always_comb begin
        state_nxt_s       = state_r;
        rr_nxt_s          = rr_r;
        owner_nxt_s       = owner_r;
        cnt_nxt_s         = cnt_r;
        word_nxt_s        = word_r;
        param_nxt_s       = param_r;
        grant_nxt_s       = '0;
        rsp_valid_nxt_s   = '0;
        rsp_result_nxt_s  = 16'h0000;
        rsp_timeout_nxt_s = 1'b0;
        tgt_valid_nxt_s   = 1'b0;
        tgt_abort_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && (|req_valid)) begin
                    state_nxt_s = ISSUE;
                    grant_nxt_s = arb_grant_s;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_grant_s[i]) begin
                            word_nxt_s  = req_word[i*16 +: 16];
                            param_nxt_s = req_param[i*PARAM_W +: PARAM_W];
                            owner_nxt_s = IW'(i);
                            rr_nxt_s    = IW'((i + 1) % NUM_REQ);
                        end else begin
                            owner_nxt_s = owner_nxt_s;
                        end
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (tgt_ready) begin
                    tgt_valid_nxt_s = 1'b1;
                    cnt_nxt_s       = '0;
                    state_nxt_s     = WAIT;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT: begin
                cnt_nxt_s = cnt_r + TO_W'(1);
                // done takes priority over an expiry on the same cycle
                if (tgt_done) begin
                    state_nxt_s      = RESPOND;
                    rsp_valid_nxt_s  = owner_onehot_s;
                    rsp_result_nxt_s = tgt_result;
                end else if (TO_EN && (cnt_r == TO_LAST)) begin
                    state_nxt_s       = RESPOND;
                    tgt_abort_nxt_s   = 1'b1;
                    rsp_valid_nxt_s   = owner_onehot_s;
                    rsp_timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESPOND: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            rr_r          <= '0;
            owner_r       <= '0;
            cnt_r         <= '0;
            word_r        <= 16'h0000;
            param_r       <= '0;
            grant_r       <= '0;
            rsp_valid_r   <= '0;
            rsp_result_r  <= 16'h0000;
            rsp_timeout_r <= 1'b0;
            tgt_valid_r   <= 1'b0;
            tgt_abort_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            rr_r          <= rr_nxt_s;
            owner_r       <= owner_nxt_s;
            cnt_r         <= cnt_nxt_s;
            word_r        <= word_nxt_s;
            param_r       <= param_nxt_s;
            grant_r       <= grant_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_result_r  <= rsp_result_nxt_s;
            rsp_timeout_r <= rsp_timeout_nxt_s;
            tgt_valid_r   <= tgt_valid_nxt_s;
            tgt_abort_r   <= tgt_abort_nxt_s;
            busy_r        <= (state_nxt_s != IDLE);
        end
    end

    assign req_grant   = grant_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_timeout = rsp_timeout_r;
    assign tgt_valid   = tgt_valid_r;
    assign tgt_word    = word_r;
    assign tgt_param   = param_r;
    assign tgt_abort   = tgt_abort_r;
    assign busy        = busy_r;

    bridge_target_cmd_arb_chk #(
        .NUM_REQ (NUM_REQ),
        .PARAM_W (PARAM_W)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .state     (state_r),
        .req_grant (grant_r),
        .rsp_valid (rsp_valid_r),
        .tgt_valid (tgt_valid_r),
        .tgt_word  (word_r),
        .tgt_param (param_r)
    );

endmodule

// File: tb/tb_bridge_target_cmd_arb.sv
// Directed testbench for bridge_target_cmd_arb (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_bridge_target_cmd_arb;

    localparam int NR = 4;
    localparam int PW = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [NR-1:0]    req_valid;
    logic [NR*16-1:0] req_word;
    logic [NR*PW-1:0] req_param;
    logic [NR-1:0]    req_grant;
    logic [NR-1:0]    rsp_valid;
    logic [15:0]      rsp_result;
    logic             rsp_timeout;
    logic             tgt_valid;
    logic [15:0]      tgt_word;
    logic [PW-1:0]    tgt_param;
    logic             tgt_ready;
    logic             tgt_done;
    logic [15:0]      tgt_result;
    logic             tgt_abort;
    logic             busy;

    int errors = 0;
    int checks = 0;

    bridge_target_cmd_arb #(
        .NUM_REQ        (NR),
        .PARAM_W        (PW),
        .TIMEOUT_CYCLES (16),
        .TO_W           (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_word    (req_word),
        .req_param   (req_param),
        .req_grant   (req_grant),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_timeout (rsp_timeout),
        .tgt_valid   (tgt_valid),
        .tgt_word    (tgt_word),
        .tgt_param   (tgt_param),
        .tgt_ready   (tgt_ready),
        .tgt_done    (tgt_done),
        .tgt_result  (tgt_result),
        .tgt_abort   (tgt_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        req_valid  = '0;
        req_word   = '0;
        req_param  = '0;
        tgt_ready  = 1'b0;
        tgt_done   = 1'b0;
        tgt_result = 16'h0000;
        tick();
        tick();

        // reset state
        check("rst_outs", {req_grant, rsp_valid, rsp_result, rsp_timeout, tgt_valid, tgt_abort, busy}, 64'd0);
        check("rst_word", tgt_word, 64'd0);
        check("rst_param", tgt_param, 64'd0);
        reset  = 1'b0;
        enable = 1'b1;

        // single request from requester 2
        req_word[2*16 +: 16]  = 16'h0180;
        req_param[2*PW +: PW] = 64'h1234;
        req_valid = 4'b0100;
        tgt_ready = 1'b1;
        tick();
        check("t1_grant", req_grant, 64'h4);
        check("t1_busy", busy, 64'd1);
        check("t1_no_issue_yet", tgt_valid, 64'd0);
        req_valid = 4'b0000;
        tick();
        check("t1_tgt_valid", tgt_valid, 64'd1);
        check("t1_tgt_word", tgt_word, 64'h0180);
        check("t1_tgt_param", tgt_param, 64'h1234);
        tick();
        check("t1_valid_pulse", tgt_valid, 64'd0);
        repeat (3) tick();
        tgt_done   = 1'b1;
        tgt_result = 16'h0001;
        tick();
        tgt_done = 1'b0;
        check("t1_rsp_valid", rsp_valid, 64'h4);
        check("t1_rsp_result", rsp_result, 64'h0001);
        check("t1_rsp_timeout", rsp_timeout, 64'd0);
        check("t1_rr", dut.rr_r, 64'd3);
        tick();
        check("t1_idle", {rsp_valid, busy}, 64'd0);

        // round robin from rr=0 with all requesters held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_word[i*16 +: 16]  = 16'h0200 + 16'(i);
            req_param[i*PW +: PW] = 64'hC0DE_0000 + 64'(i);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % NR;
            tick();
            check("rr_grant", req_grant, 64'(4'b0001 << e));
            tick();
            check("rr_tgt_valid", tgt_valid, 64'd1);
            check("rr_tgt_word", tgt_word, 64'(16'h0200 + 16'(e)));
            tgt_done   = 1'b1;
            tgt_result = 16'h00A0 + 16'(e);
            tick();
            tgt_done = 1'b0;
            check("rr_rsp_valid", rsp_valid, 64'(4'b0001 << e));
            check("rr_rsp_result", rsp_result, 64'(16'h00A0 + 16'(e)));
            if (k == 4) begin
                req_valid = 4'b0000;
            end
            tick();
            check("rr_idle_busy", busy, 64'd0);
        end
        check("rr_ptr", dut.rr_r, 64'd1);

        // timeout: requester 1, engine never answers
        req_word[1*16 +: 16] = 16'h0300;
        req_valid = 4'b0010;
        tick();
        check("to_grant", req_grant, 64'h2);
        req_valid = 4'b0000;
        tick();
        check("to_tgt_valid", tgt_valid, 64'd1);
        for (int c = 1; c < 16; c++) begin
            tick();
            check("to_early", {tgt_abort, rsp_valid}, 64'd0);
        end
        tick();
        check("to_abort", tgt_abort, 64'd1);
        check("to_rsp_valid", rsp_valid, 64'h2);
        check("to_rsp_timeout", rsp_timeout, 64'd1);
        check("to_rsp_result", rsp_result, 64'd0);
        tick();
        check("to_abort_pulse", tgt_abort, 64'd0);
        tick();
        tick();
        tgt_done   = 1'b1;
        tgt_result = 16'hBEEF;
        tick();
        tgt_done = 1'b0;
        check("to_late_done", {rsp_valid, busy}, 64'd0);
        tick();
        check("to_late_done2", rsp_valid, 64'd0);

        // ready stall, then enable dropped during WAIT
        req_word[2*16 +: 16] = 16'h0400;
        req_valid = 4'b0100;
        tgt_ready = 1'b0;
        tick();
        check("st_grant", req_grant, 64'h4);
        req_valid = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("st_no_issue", tgt_valid, 64'd0);
        end
        tgt_ready = 1'b1;
        tick();
        check("st_tgt_valid", tgt_valid, 64'd1);
        check("st_tgt_word", tgt_word, 64'h0400);
        enable = 1'b0;
        req_word[3*16 +: 16] = 16'h0500;
        req_valid = 4'b1000;
        tick();
        tick();
        tgt_done   = 1'b1;
        tgt_result = 16'h0055;
        tick();
        tgt_done = 1'b0;
        check("st_rsp_valid", rsp_valid, 64'h4);
        check("st_rsp_result", rsp_result, 64'h0055);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("st_disabled", {req_grant, busy}, 64'd0);
        end
        enable = 1'b1;
        tick();
        check("st_resume_grant", req_grant, 64'h8);
        req_valid = 4'b0000;
        tick();
        check("st2_tgt_word", tgt_word, 64'h0500);

        // reset mid-WAIT with requests pending
        req_valid = 4'b1010;
        tick();
        reset = 1'b1;
        tick();
        check("rw_outs", {req_grant, rsp_valid, rsp_result, rsp_timeout, tgt_valid, tgt_abort, busy}, 64'd0);
        check("rw_word", tgt_word, 64'd0);
        check("rw_param", tgt_param, 64'd0);
        check("rw_rr", dut.rr_r, 64'd0);
        reset = 1'b0;
        tick();
        check("rw_grant", req_grant, 64'h2);
        req_valid = 4'b0000;

        // done arrives on the expiry cycle
        tick();
        check("co_tgt_valid", tgt_valid, 64'd1);
        repeat (15) tick();
        tgt_done   = 1'b1;
        tgt_result = 16'h0077;
        tick();
        tgt_done = 1'b0;
        check("co_rsp_valid", rsp_valid, 64'h2);
        check("co_rsp_timeout", rsp_timeout, 64'd0);
        check("co_rsp_result", rsp_result, 64'h0077);
        check("co_no_abort", tgt_abort, 64'd0);
        tick();
        check("co_idle", {tgt_abort, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
